// File: rtl/ws2812_pkg.sv
// Shared types and cycle-count helpers for the WS2812 serialiser.
// WS2812_RGBW_EN widens pixels from 24 (GRB) to 32 (GRBW) bits.
package ws2812_pkg;

`ifdef WS2812_RGBW_EN
    localparam int unsigned PIXEL_BITS = 32;
`else
    localparam int unsigned PIXEL_BITS = 24;
`endif

    localparam int unsigned BIT_IDX_W = $clog2(PIXEL_BITS);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        LATCH
    } state_t;

    function automatic int unsigned cyc_per_us(input int unsigned sys_clk);
        return sys_clk / 1_000_000;
    endfunction

    // Truncating ns -> cycles, scaled through whole cycles-per-microsecond.
    function automatic int unsigned ns_to_cyc(input int unsigned sys_clk, input int unsigned ns);
        return (cyc_per_us(sys_clk) * ns) / 1000;
    endfunction

    function automatic int unsigned us_to_cyc(input int unsigned sys_clk, input int unsigned us);
        return cyc_per_us(sys_clk) * us;
    endfunction

    // Counter width that stays at least one bit for n <= 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ws2812_bit_gen.sv
// One WS2812 bit period: BIT_CYC cycles, high for T1H_CYC or T0H_CYC.
// A start strobe on the last cycle of a period chains the next bit with no gap.
module ws2812_bit_gen
    import ws2812_pkg::*;
#(
    parameter int unsigned T0H_CYC = 20,
    parameter int unsigned T1H_CYC = 40,
    parameter int unsigned BIT_CYC = 62
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic i_start,
    input  logic i_bit,
    output logic o_do,
    output logic o_bit_end_c
);

    localparam int unsigned CNT_W = cnt_width(BIT_CYC);

    logic [CNT_W-1:0] r_cnt;
    logic             r_active;
    logic             r_bit;
    logic             r_do;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_active_nxt;
    logic             w_bit_nxt;
    logic             w_do_nxt;

    assign o_bit_end_c = r_active && (r_cnt == CNT_W'(BIT_CYC - 1));
    assign o_do        = r_do;

    // Output is registered from the next count so it lines up with that count.
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_active_nxt = r_active;
        w_bit_nxt    = r_bit;
        w_do_nxt     = 1'b0;
        if (i_start) begin
            w_cnt_nxt    = '0;
            w_active_nxt = 1'b1;
            w_bit_nxt    = i_bit;
        end else if (r_active) begin
            if (o_bit_end_c) begin
                w_cnt_nxt    = '0;
                w_active_nxt = 1'b0;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
        w_do_nxt = w_active_nxt && (32'(w_cnt_nxt) < (w_bit_nxt ? T1H_CYC : T0H_CYC));
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_bit    <= 1'b0;
            r_do     <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_active <= w_active_nxt;
            r_bit    <= w_bit_nxt;
            r_do     <= w_do_nxt;
        end
    end

endmodule

// File: rtl/ws2812_encoder.sv
// Reads a frame from the pixel buffer and serialises it MSB first as a WS2812 stream.
// Pixel width follows WS2812_RGBW_EN (see ws2812_pkg).
module ws2812_encoder
    import ws2812_pkg::*;
#(
    parameter int unsigned  SYSTEM_CLOCK = 50_000_000,
    parameter int unsigned  NUM_LEDS     = 256,
    parameter int unsigned  T0H_NS       = 400,
    parameter int unsigned  T1H_NS       = 800,
    parameter int unsigned  BIT_NS       = 1250,
    parameter int unsigned  LATCH_US     = 80,
    localparam int unsigned ADDR_W       = cnt_width(NUM_LEDS)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    output logic                  rd_o,
    output logic [ADDR_W-1:0]     addr_o,
    input  logic [PIXEL_BITS-1:0] data_i,
    output logic                  do_o,
    output logic                  bsy_o,
    output logic                  done_o
);

    localparam int unsigned T0H_CYC   = ns_to_cyc(SYSTEM_CLOCK, T0H_NS);
    localparam int unsigned T1H_CYC   = ns_to_cyc(SYSTEM_CLOCK, T1H_NS);
    localparam int unsigned BIT_CYC   = ns_to_cyc(SYSTEM_CLOCK, BIT_NS);
    localparam int unsigned LATCH_CYC = us_to_cyc(SYSTEM_CLOCK, LATCH_US);
    localparam int unsigned LAT_W     = cnt_width(LATCH_CYC);
    localparam int unsigned MSB       = PIXEL_BITS - 1;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_rd;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_bsy;
    logic                  r_done;
    logic [LAT_W-1:0]      r_lat;
    logic                  r_rd_dly;
    logic                  r_first;
    logic [PIXEL_BITS-1:0] r_shift;
    logic [PIXEL_BITS-1:0] r_next;
    logic [BIT_IDX_W-1:0]  r_bit_idx;
    logic [ADDR_W-1:0]     r_pix;

    logic                  w_rd_nxt;
    logic [ADDR_W-1:0]     w_addr_nxt;
    logic                  w_bsy_nxt;
    logic                  w_done_nxt;
    logic [LAT_W-1:0]      w_lat_nxt;

    logic                  w_bit_end;
    logic                  w_bit_last;
    logic                  w_last_pix;
    logic                  w_frame_end;
    logic                  w_gen_start;
    logic                  w_gen_bit;
    logic                  w_pix_start;
    logic                  w_pix_start_last;
    logic                  w_pf;

    ws2812_bit_gen #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_bit_gen (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .i_start     (w_gen_start),
        .i_bit       (w_gen_bit),
        .o_do        (do_o),
        .o_bit_end_c (w_bit_end)
    );

    // Bit sequencing: first bit after LOAD, then chain on every bit_end except the frame's last.
    always_comb begin
        w_bit_last  = (r_bit_idx == '0);
        w_last_pix  = (32'(r_pix) == NUM_LEDS - 1);
        w_frame_end = (r_state == SHIFT) && w_bit_end && w_bit_last && w_last_pix;
        w_gen_start = (r_state == SHIFT) &&
                      (r_first || (w_bit_end && !(w_bit_last && w_last_pix)));
        w_gen_bit   = r_first    ? r_shift[MSB] :
                      w_bit_last ? r_next[MSB]  : r_shift[MSB-1];
        // A pixel's MSB is starting: the first pixel, or the next one at a boundary.
        w_pix_start      = r_first || w_bit_last;
        w_pix_start_last = r_first ? w_last_pix : (32'(r_pix) + 32'd1 == NUM_LEDS - 1);
        w_pf             = w_gen_start && w_pix_start && !w_pix_start_last;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_bsy_nxt   = r_bsy;
        w_done_nxt  = 1'b0;
        w_lat_nxt   = '0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = FETCH;
                    w_rd_nxt    = 1'b1;
                    w_addr_nxt  = '0;
                    w_bsy_nxt   = 1'b1;
                end
            end
            FETCH: begin
                w_state_nxt = LOAD;
            end
            LOAD: begin
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (w_pf) begin
                    w_rd_nxt   = 1'b1;
                    w_addr_nxt = r_addr + ADDR_W'(1);
                end
                if (w_frame_end) begin
                    w_state_nxt = LATCH;
                    w_done_nxt  = (LATCH_CYC == 1);
                end
            end
            LATCH: begin
                w_lat_nxt = r_lat + LAT_W'(1);
                if (32'(r_lat) == LATCH_CYC - 1) begin
                    w_state_nxt = IDLE;
                    w_bsy_nxt   = 1'b0;
                    w_lat_nxt   = '0;
                end else if (32'(r_lat) + 32'd1 == LATCH_CYC - 1) begin
                    w_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_bsy_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_rd   <= 1'b0;
            r_addr <= '0;
            r_bsy  <= 1'b0;
            r_done <= 1'b0;
            r_lat  <= '0;
        end else begin
            r_rd   <= w_rd_nxt;
            r_addr <= w_addr_nxt;
            r_bsy  <= w_bsy_nxt;
            r_done <= w_done_nxt;
            r_lat  <= w_lat_nxt;
        end
    end

    // Shift register, bit/pixel counters and the prefetched next-pixel word.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_rd_dly  <= 1'b0;
            r_first   <= 1'b0;
            r_shift   <= '0;
            r_next    <= '0;
            r_bit_idx <= '0;
            r_pix     <= '0;
        end else begin
            r_rd_dly <= r_rd;
            r_first  <= (r_state == LOAD);
            if (r_state == LOAD) begin
                r_shift   <= data_i;
                r_bit_idx <= BIT_IDX_W'(MSB);
                r_pix     <= '0;
            end else if ((r_state == SHIFT) && w_bit_end) begin
                if (w_bit_last) begin
                    if (!w_last_pix) begin
                        r_shift   <= r_next;
                        r_bit_idx <= BIT_IDX_W'(MSB);
                        r_pix     <= r_pix + ADDR_W'(1);
                    end
                end else begin
                    r_shift   <= {r_shift[MSB-1:0], 1'b0};
                    r_bit_idx <= r_bit_idx - BIT_IDX_W'(1);
                end
            end
            if (r_rd_dly) begin
                r_next <= data_i;
            end
        end
    end

    assign rd_o   = r_rd;
    assign addr_o = r_addr;
    assign bsy_o  = r_bsy;
    assign done_o = r_done;

endmodule

// File: tb/tb_ws2812_encoder.sv
// Bench for ws2812_encoder: a two-pixel and a one-pixel instance checked against
// a waveform model built from the bit rules. Honours WS2812_RGBW_EN.
`timescale 1ns/1ps
module tb_ws2812_encoder;

`ifdef WS2812_RGBW_EN
    localparam int PB = 32;
`else
    localparam int PB = 24;
`endif
    localparam int CPU  = 50_000_000 / 1_000_000;
    localparam int T0H  = CPU * 400 / 1000;
    localparam int T1H  = CPU * 800 / 1000;
    localparam int BITC = CPU * 1250 / 1000;
    localparam int LAT  = CPU * 80;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst2, start2, rd2, do2, bsy2, done2;
    logic [0:0]    a2;
    logic [PB-1:0] d2;
    logic          rst1, start1, rd1, do1, bsy1, done1;
    logic [0:0]    a1;
    logic [PB-1:0] d1;

    ws2812_encoder #(.NUM_LEDS(2)) u_dut2 (
        .clk_i(clk), .reset_i(rst2), .start_i(start2), .rd_o(rd2), .addr_o(a2),
        .data_i(d2), .do_o(do2), .bsy_o(bsy2), .done_o(done2)
    );

    ws2812_encoder #(.NUM_LEDS(1)) u_dut1 (
        .clk_i(clk), .reset_i(rst1), .start_i(start1), .rd_o(rd1), .addr_o(a1),
        .data_i(d1), .do_o(do1), .bsy_o(bsy1), .done_o(done1)
    );

    // Pixel buffer: data valid one cycle after rd, garbage otherwise.
    logic [PB-1:0] mem2 [2];
    logic [PB-1:0] mem1;
    always @(posedge clk) begin
        d2 <= rd2 ? mem2[a2] : PB'($urandom);
        d1 <= rd1 ? mem1 : PB'($urandom);
    end

    int   sel;
    logic s_do, s_bsy, s_done, s_rd;
    int   s_addr;
    always_comb begin
        if (sel == 1) begin
            s_do = do1; s_bsy = bsy1; s_done = done1; s_rd = rd1; s_addr = int'(a1);
        end else begin
            s_do = do2; s_bsy = bsy2; s_done = done2; s_rd = rd2; s_addr = int'(a2);
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    logic [PB-1:0] pix[$];
    logic          exp_do[$];
    int            exp_done;
    logic          cap_do[$];
    logic          cap_bsy[$];
    int            cap_done[$];
    int            cap_rd[$];

    task automatic set_start(input logic v);
        if (sel == 1) start1 = v;
        else          start2 = v;
    endtask

    task automatic load_mem();
        if (sel == 1) mem1 = pix[0];
        else foreach (pix[i]) mem2[i] = pix[i];
    endtask

    // Sample index k is taken just after the k-th edge following the one that accepts start.
    task automatic build_exp();
        exp_do.delete();
        repeat (3) exp_do.push_back(1'b0);
        foreach (pix[p]) begin
            for (int b = PB - 1; b >= 0; b--) begin
                int h;
                h = pix[p][b] ? T1H : T0H;
                for (int c = 0; c < BITC; c++) exp_do.push_back(c < h);
            end
        end
        repeat (LAT) exp_do.push_back(1'b0);
        exp_done = exp_do.size() - 1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
    endtask

    task automatic capture(input int again_at);
        cap_do.delete(); cap_bsy.delete(); cap_done.delete(); cap_rd.delete();
        for (int k = 0; k < exp_do.size() + 20; k++) begin
            cap_do.push_back(s_do);
            cap_bsy.push_back(s_bsy);
            if (s_done) cap_done.push_back(k);
            if (s_rd) cap_rd.push_back(s_addr);
            set_start(k == again_at);
            if (cap_done.size() > 0 && k >= cap_done[0] + 2) break;
            @(negedge clk);
        end
        set_start(1'b0);
    endtask

    function automatic int first_rise();
        foreach (cap_do[k]) if (cap_do[k] === 1'b1) return k;
        return -1;
    endfunction

    task automatic check_frame(input string nm);
        int   bad_k, n_bad, rise_k, exp_len, got_done;
        logic expv;
        bad_k = -1; n_bad = 0;
        for (int k = 0; k < exp_do.size() + 2; k++) begin
            expv = (k < exp_do.size()) ? exp_do[k] : 1'b0;
            if (k >= cap_do.size() || cap_do[k] !== expv) begin
                n_bad++;
                if (bad_k < 0) bad_k = k;
            end
        end
        n_chk++;
        if (n_bad != 0) $display("FAIL %s wave: %0d wrong samples (first at %0d), required 0", nm, n_bad, bad_k);
        else n_pass++;

        n_chk++;
        if (cap_done.size() != 1) $display("FAIL %s done_count: got %0d required 1", nm, cap_done.size());
        else n_pass++;

        got_done = (cap_done.size() > 0) ? cap_done[0] : -1;
        n_chk++;
        if (got_done != exp_done) $display("FAIL %s done_cycle: got %0d required %0d", nm, got_done, exp_done);
        else n_pass++;

        // Inclusive of the first high cycle and the done cycle.
        rise_k  = first_rise();
        exp_len = pix.size() * PB * BITC + LAT;
        n_chk++;
        if (rise_k < 0 || got_done < 0 || got_done - rise_k + 1 != exp_len)
            $display("FAIL %s frame_len: got %0d required %0d", nm, got_done - rise_k + 1, exp_len);
        else n_pass++;

        n_bad = (cap_bsy.size() < exp_done + 2) ? 1 : 0;
        foreach (cap_bsy[k]) if (cap_bsy[k] !== (k <= exp_done)) n_bad++;
        n_chk++;
        if (n_bad != 0) $display("FAIL %s bsy_window: %0d wrong samples, required 0", nm, n_bad);
        else n_pass++;

        n_chk++;
        if (cap_rd.size() != pix.size()) $display("FAIL %s rd_count: got %0d required %0d", nm, cap_rd.size(), pix.size());
        else n_pass++;

        n_bad = 0;
        foreach (cap_rd[i]) if (cap_rd[i] != i) n_bad++;
        n_chk++;
        if (n_bad != 0) $display("FAIL %s rd_addr: %0d out-of-order addresses, required 0", nm, n_bad);
        else n_pass++;
    endtask

    task automatic test_reset();
        sel = 2;
        rst2 = 1'b0; rst1 = 1'b0; start2 = 1'b0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (do2 !== 1'b0)   $display("FAIL rst_do: got %b required 0", do2);     else n_pass++;
        n_chk++; if (bsy2 !== 1'b0)  $display("FAIL rst_bsy: got %b required 0", bsy2);  else n_pass++;
        n_chk++; if (done2 !== 1'b0) $display("FAIL rst_done: got %b required 0", done2); else n_pass++;
        n_chk++; if (rd2 !== 1'b0)   $display("FAIL rst_rd: got %b required 0", rd2);     else n_pass++;
        n_chk++; if (a2 !== 1'b0)    $display("FAIL rst_addr: got %b required 0", a2);    else n_pass++;
        n_chk++; if (do1 !== 1'b0)   $display("FAIL rst_do1: got %b required 0", do1);    else n_pass++;
        n_chk++; if (bsy1 !== 1'b0)  $display("FAIL rst_bsy1: got %b required 0", bsy1);  else n_pass++;
        rst2 = 1'b1; rst1 = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        int rises[$];
        sel = 2;
        pix.delete();
        pix.push_back(PB'(1) << (PB - 1));
        pix.push_back(PB'(1));
        build_exp(); load_mem();
        pulse_start();
        capture(-1);
        check_frame("basic");
        n_chk++;
        if (first_rise() != 3) $display("FAIL first_rise: got %0d required 3", first_rise());
        else n_pass++;
        foreach (cap_do[k]) if (cap_do[k] === 1'b1 && (k == 0 || cap_do[k-1] === 1'b0)) rises.push_back(k);
        n_chk++;
        if (rises.size() <= PB || rises[PB] - rises[PB-1] != BITC)
            $display("FAIL pixel_boundary: got %0d required %0d", (rises.size() > PB) ? rises[PB] - rises[PB-1] : -1, BITC);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        sel = 2;
        pix.delete();
        repeat (2) pix.push_back(PB'($urandom));
        build_exp(); load_mem();
        pulse_start();
        capture(500);
        check_frame("start_ignored");
    endtask

    task automatic test_reset_midframe();
        int target;
        sel = 2;
        pix.delete();
        repeat (2) pix.push_back(PB'($urandom));
        build_exp(); load_mem();
        target = 3 + PB * BITC + 5 * BITC + 2;
        pulse_start();
        for (int k = 0; k < target - 1; k++) @(negedge clk);
        n_chk++;
        if (do2 !== exp_do[target-1]) $display("FAIL pre_reset_do: got %b required %b", do2, exp_do[target-1]);
        else n_pass++;
        rst2 = 1'b0;
        @(negedge clk);
        n_chk++; if (do2 !== 1'b0)  $display("FAIL midrst_do: got %b required 0", do2);   else n_pass++;
        n_chk++; if (bsy2 !== 1'b0) $display("FAIL midrst_bsy: got %b required 0", bsy2); else n_pass++;
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        pix.delete();
        repeat (2) pix.push_back(PB'($urandom));
        build_exp(); load_mem();
        pulse_start();
        capture(-1);
        check_frame("after_reset");
    endtask

    task automatic test_random();
        sel = 2;
        for (int f = 0; f < 2; f++) begin
            pix.delete();
            repeat (2) pix.push_back(PB'($urandom));
            build_exp(); load_mem();
            pulse_start();
            capture(-1);
            check_frame("random");
        end
    endtask

    task automatic test_single_led();
        sel = 1;
        pix.delete();
`ifdef WS2812_RGBW_EN
        pix.push_back(PB'(1));
`else
        pix.push_back({PB{1'b1}});
`endif
        build_exp(); load_mem();
        pulse_start();
        capture(-1);
        check_frame("single_led");
    endtask

    initial begin
        sel = 2;
        rst2 = 1'b0; rst1 = 1'b0; start2 = 1'b0; start1 = 1'b0;
        mem2[0] = '0; mem2[1] = '0; mem1 = '0;
        test_reset();
        test_basic_frame();
        test_start_ignored();
        test_reset_midframe();
        test_random();
        test_single_led();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ws2812_encoder.md
Name: ws2812_encoder

Overview:
- Downstream stage of the SPI pixel receiver; reads a completed frame from the pixel buffer and serialises it as a WS2812 (NeoPixel) single-wire bitstream on do_o.
- One instance per strip, fed by the pixel-buffer read port, driving one GPIO output and the strip-busy indicator.
- Frame = NUM_LEDS pixels × 24 bits, sent MSB first in buffer order (GRB as stored), followed by a low latch interval.

Parameters:
- SYSTEM_CLOCK, 50_000_000: clock frequency in Hz.
- NUM_LEDS, 256: pixels per frame; legal range 1..4096.
- T0H_NS, 400: high time for a 0 bit, in ns.
- T1H_NS, 800: high time for a 1 bit, in ns.
- BIT_NS, 1250: total bit period, in ns.
- LATCH_US, 80: low time after the last bit, in µs.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-low reset
- start_i  in  1  one-cycle frame-send request
- rd_o  out  1  pixel-buffer read strobe
- addr_o  out  $clog2(NUM_LEDS)  pixel-buffer read address
- data_i  in  24  pixel word; valid exactly one cycle after rd_o
- do_o  out  1  WS2812 data out
- bsy_o  out  1  high from start acceptance through end of latch
- done_o  out  1  one-cycle pulse when the latch completes

Behaviour:
- Cycle counts are truncating integers:
  - CYC_PER_US = SYSTEM_CLOCK/1_000_000.
  - T0H = CYC_PER_US*T0H_NS/1000, T1H and BIT the same way. At defaults: T0H=20, T1H=40, BIT=62.
  - LATCH = CYC_PER_US*LATCH_US (default 4000).
- Reset (reset_i low at a clk_i edge): do_o=0, bsy_o=0, done_o=0, rd_o=0, addr_o=0, state IDLE. Applies mid-frame too: the frame is abandoned and the output goes low on that edge.
- FSM states: IDLE, FETCH, LOAD, SHIFT, LATCH.
  - IDLE: on start_i=1, go to FETCH, set bsy_o=1 and addr_o=0. start_i is ignored in every other state; no queueing.
  - FETCH: rd_o=1 for one cycle, then go to LOAD.
  - LOAD: capture data_i into the 24-bit shift register, reset the bit counter to 23, go to SHIFT. The first rising edge of do_o is 3 cycles after the start_i edge.
  - SHIFT: a bit-period counter runs 0..BIT-1.
    - do_o=1 while count < (current bit ? T1H : T0H), else 0.
    - At count BIT-1: shift left and decrement the bit counter.
    - After bit 0 of the last pixel completes, go to LATCH.
  - Prefetch during SHIFT: when bit counter=23 and count=0 of a pixel other than the last, assert rd_o for one cycle with addr_o+1. Latch data_i into the next-pixel register one cycle later.
  - Pixel boundary: the next pixel's first bit starts on the cycle after the previous bit's BIT-1. No gap; every bit period is exactly BIT cycles.
  - LATCH: do_o=0 for LATCH cycles. On the final cycle, done_o=1 for that one cycle. The next cycle is IDLE with bsy_o=0.
- addr_o wraps to 0 only via a new start; it never exceeds NUM_LEDS-1.
- NUM_LEDS=1: no prefetch read occurs, and exactly one rd_o is issued per frame.
- start_i asserted in the same cycle that done_o pulses: ignored (the FSM is still in LATCH).
- Frame length in cycles from the first do_o rise to done_o = NUM_LEDS*24*BIT + LATCH.

Optional Feature:
- Macro WS2812_RGBW_EN.
- When defined: data_i is 32 bits, the shift register is 32 bits, the bit counter starts at 31, and each pixel is 32 bits (RGBW strips). Frame length = NUM_LEDS*32*BIT + LATCH.
- When undefined: 24-bit behaviour as above. No other differences.

Decomposition:
- Package ws2812_pkg holds:
  - the state enum (IDLE, FETCH, LOAD, SHIFT, LATCH);
  - PIXEL_BITS (24, or 32 under WS2812_RGBW_EN);
  - the cycle-count helper functions for T0H/T1H/BIT/LATCH.
- One sub-module, ws2812_bit_gen, owns the bit-period counter and the do_o high-time compare.
  - Inputs: bit value and a start strobe.
  - Outputs: do_o and a bit_end strobe.
  - The encoder FSM handles fetch, shift register and latch.

Test Plan:
- NUM_LEDS=2, buffer {0x800000, 0x000001}, start_i pulse:
  - bit 0 high 40 cycles then low 22;
  - bits 1..23 high 20 cycles each;
  - second pixel: bits 0..22 high 20, bit 23 high 40;
  - then low 4000 cycles, done_o once, bsy_o low the next cycle.
- Pixel boundary at defaults: measure the interval between consecutive do_o rising edges across the pixel-0/pixel-1 boundary -> exactly 62 cycles; rd_o pulses exactly 2 times, addresses 0 then 1.
- start_i pulsed again mid-frame (cycle 500) -> ignored; frame length unchanged at 2*24*62+4000 cycles; exactly one done_o.
- reset_i driven low during pixel 1, bit 5, high phase -> do_o=0 and bsy_o=0 at that edge; after release, a new start sends a full frame from addr 0.
- NUM_LEDS=1, data 0xFFFFFF -> one rd_o; 24 bits high 40 cycles each; done_o at 24*62+4000 cycles after the first rise.
- WS2812_RGBW_EN defined, NUM_LEDS=1, data 0x0000_0001 -> 32 bits, only the last bit high 40 cycles; done_o at 32*62+4000 cycles after the first rise.
